// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes,
// FSM state constants and size/extension helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            F3_LB:   extend = {{24{d[7]}}, d[7:0]};
            F3_LH:   extend = {{16{d[15]}}, d[15:0]};
            F3_LBU:  extend = {24'h000000, d[7:0]};
            F3_LHU:  extend = {16'h0000, d[15:0]};
            default: extend = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_unit_lane_shift.sv
// Byte-lane mask and data shift for one half of an access. LOAD selects the
// direction: stores move right-justified data into lanes, loads move lanes down.
module lsu_lane_shift
    import lsu_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        part,
    input  logic [31:0] data_in,
    output logic [3:0]  mask,
    output logic [31:0] data_out
);

    logic [3:0] size_mask;
    logic [2:0] n;
    logic [5:0] sh_lo;
    logic [5:0] sh_hi;

    always_comb begin
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        // n is the byte count spilling into the next word; only meaningful when split
        n     = {1'b0, off} + size - 3'd4;
        sh_lo = {1'b0, off, 3'b000};
        sh_hi = 6'd32 - sh_lo;
        if (!part) begin
            mask = size_mask << off;
        end else begin
            mask = (4'b0001 << n) - 4'b0001;
        end
        if (LOAD) begin
            data_out = part ? (data_in << sh_hi) : (data_in >> sh_lo);
        end else begin
            data_out = part ? (data_in >> sh_hi) : (data_in << sh_lo);
        end
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store unit: maps byte-addressed RISC-V loads/stores onto a word memory,
// splitting accesses that straddle a word boundary into two cycles.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    input  logic              ls_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       byte_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              stall,
    output logic              fault,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [0:0]        dbg_state
);

    // Handshake: a request is presented with ls_valid; it completes in the cycle
    // done=1. While stall=1 the core holds every request input stable.

    logic [0:0]        state, state_nx;
    logic [DATA_W-1:0] hold_data;
    logic [1:0]        off;
    logic [2:0]        size;
    logic              legal, out_of_range, top_word, split, bad, part, capture;
    logic [ADDR_W-1:0] word_a;
    logic [3:0]        st_mask, ld_mask;
    logic [31:0]       st_data, ld_data, rd_masked;

    assign off          = byte_addr[1:0];
    assign size         = size_of(funct3);
    assign word_a       = byte_addr[ADDR_W+1:2];
    assign legal        = ls_store ? (funct3 inside {F3_SB, F3_SH, F3_SW})
                                   : (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign out_of_range = |byte_addr[31:ADDR_W+2];
    assign top_word     = &byte_addr[ADDR_W+1:2];
    assign split        = ({2'b00, off} + {1'b0, size}) > 4'd4;
    assign bad          = !legal || out_of_range || (split && top_word);
    assign part         = (state == ST_SECOND);
    assign dbg_state    = state;

    // Lanes outside the current half are cleared so the halves merge with a plain OR.
    assign rd_masked = mem_rdata & {{8{ld_mask[3]}}, {8{ld_mask[2]}},
                                    {8{ld_mask[1]}}, {8{ld_mask[0]}}};

    lsu_lane_shift #(.LOAD(1'b0)) u_store_shift (
        .off      (off),
        .size     (size),
        .part     (part),
        .data_in  (store_data),
        .mask     (st_mask),
        .data_out (st_data)
    );

    lsu_lane_shift #(.LOAD(1'b1)) u_load_shift (
        .off      (off),
        .size     (size),
        .part     (part),
        .data_in  (rd_masked),
        .mask     (ld_mask),
        .data_out (ld_data)
    );

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        mem_cs    = 1'b1;
        mem_wr    = 1'b1;
        mem_mask  = 4'b0000;
        mem_addr  = word_a;
        mem_wdata = '0;
        done      = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        load_data = '0;
        if (!rst) begin
            if (state == ST_IDLE) begin
                if (ls_valid) begin
                    if (bad) begin
                        fault = 1'b1;
                        done  = 1'b1;
                    end else begin
                        mem_cs    = 1'b0;
                        mem_wr    = !ls_store;
                        mem_mask  = ls_store ? st_mask : 4'b0000;
                        mem_wdata = ls_store ? st_data : '0;
                        if (split) begin
                            stall    = 1'b1;
                            capture  = !ls_store;
                            state_nx = ST_SECOND;
                        end else begin
                            done = 1'b1;
                            if (!ls_store) load_data = extend(ld_data, funct3);
                        end
                    end
                end
            end else begin
                // An abort (ls_valid dropped) simply falls back to IDLE with no access.
                state_nx = ST_IDLE;
                if (ls_valid) begin
                    mem_cs    = 1'b0;
                    mem_wr    = !ls_store;
                    mem_addr  = word_a + ADDR_W'(1);
                    mem_mask  = ls_store ? st_mask : 4'b0000;
                    mem_wdata = ls_store ? st_data : '0;
                    done      = 1'b1;
                    if (!ls_store) load_data = extend(hold_data | ld_data, funct3);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_data <= '0;
        end else begin
            state <= state_nx;
            if (capture) hold_data <= ld_data;
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: a byte-level reference memory predicts
// every cycle's outputs, with literal pins on key load results and memory words.
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_valid, ls_store;
    logic [2:0]  funct3;
    logic [31:0] byte_addr, store_data, load_data, mem_wdata, mem_rdata;
    logic        done, stall, fault, mem_cs, mem_wr;
    logic [3:0]  mem_mask;
    logic [9:0]  mem_addr;
    logic [0:0]  dbg_state;

    logic [31:0] mem_words [0:1023];
    logic [7:0]  ref_mem   [0:4095];

    typedef struct {
        logic        cs, wr;
        logic [3:0]  mask;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        done, stall, fault;
        logic [31:0] ld;
        logic        st;
        bit          chk_wm, chk_addr, chk_wd, chk_ld;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_ld  = '0;

    lsu_align_unit #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ls_valid   (ls_valid),
        .ls_store   (ls_store),
        .funct3     (funct3),
        .byte_addr  (byte_addr),
        .store_data (store_data),
        .load_data  (load_data),
        .done       (done),
        .stall      (stall),
        .fault      (fault),
        .mem_cs     (mem_cs),
        .mem_wr     (mem_wr),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset block and memory environment
    always #5 clk = ~clk;

    assign mem_rdata = mem_words[mem_addr];

    always @(negedge clk) begin
        if (!mem_cs && !mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem_words[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // reference model
    function automatic int model_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit store, input logic [2:0] f3);
        if (store) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v = '0;
        int a = int'(addr);
        for (int b = 0; b < model_size(f3); b++) v[8*b +: 8] = ref_mem[a+b];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic exp_t quiet_exp(input bit in_second, input bit in_reset);
        exp_t e;
        e.cs = 1'b1; e.wr = 1'b1; e.mask = 4'b0000; e.addr = '0; e.wdata = '0;
        e.done = 1'b0; e.stall = 1'b0; e.fault = 1'b0; e.ld = '0; e.st = in_second;
        e.chk_wm = 1'b1; e.chk_addr = 1'b0; e.chk_wd = 1'b0; e.chk_ld = in_reset;
        return e;
    endfunction

    task automatic push(input exp_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // compare process: one expected record per cycle, sampled mid-high-phase
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check32({t, ":cs"},    32'(mem_cs),    32'(e.cs));
                check32({t, ":done"},  32'(done),      32'(e.done));
                check32({t, ":stall"}, 32'(stall),     32'(e.stall));
                check32({t, ":fault"}, 32'(fault),     32'(e.fault));
                check32({t, ":state"}, 32'(dbg_state), 32'(e.st));
                if (e.chk_wm) begin
                    check32({t, ":wr"},   32'(mem_wr),   32'(e.wr));
                    check32({t, ":mask"}, 32'(mem_mask), 32'(e.mask));
                end
                if (e.chk_addr) check32({t, ":addr"},  32'(mem_addr), 32'(e.addr));
                if (e.chk_wd)   check32({t, ":wdata"}, mem_wdata, e.wdata);
                if (e.chk_ld) begin
                    check32({t, ":load"}, load_data, e.ld);
                    last_ld = load_data;
                end
            end
        end
    end

    // driver tasks; mode 0 normal, 1 abort in second half, 2 reset in second half
    task automatic request(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int mode, input string tag);
        exp_t        e;
        int          size, off, lane, a;
        bit          split, flt;
        logic [3:0]  m1, m2;
        logic [31:0] expv;
        size  = model_size(f3);
        off   = int'(addr[1:0]);
        a     = int'(addr);
        split = (off + size) > 4;
        flt   = !model_legal(store, f3) || (addr >= 32'd4096) || (split && addr[11:2] == 10'h3FF);
        m1 = '0; m2 = '0;
        for (int b = 0; b < size; b++) begin
            lane = off + b;
            if (lane < 4) m1[lane] = 1'b1; else m2[lane-4] = 1'b1;
        end
        expv = flt ? 32'h0 : model_load(addr, f3);

        @(posedge clk); #1;
        ls_valid = 1'b1; ls_store = store; funct3 = f3; byte_addr = addr; store_data = data;
        e = quiet_exp(1'b0, 1'b0);
        if (flt) begin
            e.done = 1'b1; e.fault = 1'b1; e.chk_wm = 1'b0;
        end else begin
            e.cs = 1'b0; e.wr = !store; e.mask = store ? m1 : 4'b0000;
            e.addr = addr[11:2]; e.chk_addr = 1'b1;
            if (store) begin e.wdata = data << (8*off); e.chk_wd = 1'b1; end
            if (split) e.stall = 1'b1;
            else begin
                e.done = 1'b1;
                if (!store) begin e.ld = expv; e.chk_ld = 1'b1; end
            end
            if (store)
                for (int b = 0; b < size; b++)
                    if (off + b < 4) ref_mem[a+b] = data[8*b +: 8];
        end
        push(e, {tag, "_c1"});

        if (split && !flt) begin
            @(posedge clk); #1;
            if (mode == 0) begin
                e = quiet_exp(1'b1, 1'b0);
                e.cs = 1'b0; e.wr = !store; e.mask = store ? m2 : 4'b0000;
                e.addr = addr[11:2] + 10'd1; e.chk_addr = 1'b1; e.done = 1'b1;
                if (store) begin
                    e.wdata = data >> (8*(4-off)); e.chk_wd = 1'b1;
                    for (int b = 0; b < size; b++)
                        if (off + b >= 4) ref_mem[a+b] = data[8*b +: 8];
                end else begin
                    e.ld = expv; e.chk_ld = 1'b1;
                end
                push(e, {tag, "_c2"});
            end else if (mode == 1) begin
                ls_valid = 1'b0;
                push(quiet_exp(1'b1, 1'b0), {tag, "_abort"});
            end else begin
                rst = 1'b1;
                push(quiet_exp(1'b0, 1'b1), {tag, "_rst"});
                @(posedge clk); #1;
                rst = 1'b0; ls_valid = 1'b0;
                push(quiet_exp(1'b0, 1'b0), {tag, "_post"});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ls_valid = 1'b0;
            push(quiet_exp(1'b0, 1'b0), "idle");
        end
    endtask

    // literal pin on the most recent completed load, taken after its compare slot
    task automatic pin(input string name, input logic [31:0] lit);
        #4;
        check32(name, last_ld, lit);
    endtask

    initial begin
        int          diffs;
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) mem_words[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        rst = 1'b1; ls_valid = 1'b0; ls_store = 1'b0; funct3 = '0; byte_addr = '0; store_data = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            push(quiet_exp(1'b0, 1'b1), "reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push(quiet_exp(1'b0, 1'b0), "idle");

        request(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, "sw_010");
        request(1'b0, 3'b010, 32'h010, 32'h0,        0, "lw_010");   pin("pin_lw_010", 32'hDEADBEEF);
        request(1'b1, 3'b000, 32'h013, 32'h000000A5, 0, "sb_013");
        request(1'b0, 3'b000, 32'h013, 32'h0,        0, "lb_013");   pin("pin_lb_013", 32'hFFFFFFA5);
        request(1'b0, 3'b100, 32'h013, 32'h0,        0, "lbu_013");  pin("pin_lbu_013", 32'h000000A5);
        request(1'b1, 3'b010, 32'h00E, 32'h11223344, 0, "sw_00e");
        request(1'b0, 3'b010, 32'h00E, 32'h0,        0, "lw_00e");   pin("pin_lw_00e", 32'h11223344);
        request(1'b0, 3'b101, 32'h00F, 32'h0,        0, "lhu_00f");  pin("pin_lhu_00f", 32'h00002233);
        request(1'b0, 3'b010, 32'h011, 32'h0,        0, "lw_011");   pin("pin_lw_011", 32'h00A5AD11);
        idle(1);
        request(1'b1, 3'b000, 32'h007, 32'h00000080, 0, "sb_007");
        request(1'b1, 3'b000, 32'h008, 32'h00000001, 0, "sb_008");
        request(1'b0, 3'b001, 32'h007, 32'h0,        0, "lh_007a");  pin("pin_lh_007a", 32'h00000180);
        request(1'b1, 3'b000, 32'h008, 32'h000000F0, 0, "sb_008b");
        request(1'b0, 3'b001, 32'h007, 32'h0,        0, "lh_007b");  pin("pin_lh_007b", 32'hFFFFF080);
        request(1'b0, 3'b101, 32'h007, 32'h0,        0, "lhu_007");  pin("pin_lhu_007", 32'h0000F080);

        request(1'b0, 3'b011, 32'h020,      32'h0,        0, "flt_f3_ld");
        request(1'b1, 3'b100, 32'h020,      32'h12345678, 0, "flt_f3_st");
        request(1'b0, 3'b010, 32'h1000,     32'h0,        0, "flt_range");
        request(1'b0, 3'b000, 32'h80000000, 32'h0,        0, "flt_hi");
        request(1'b0, 3'b010, 32'hFFE,      32'h0,        0, "flt_top_lw");
        request(1'b1, 3'b010, 32'hFFE,      32'h55555555, 0, "flt_top_sw");
        request(1'b0, 3'b010, 32'hFFC,      32'h0,        0, "lw_ffc");    pin("pin_lw_ffc", 32'h0);
        request(1'b1, 3'b000, 32'hFFF,      32'h0000005A, 0, "sb_fff");
        request(1'b0, 3'b000, 32'hFFF,      32'h0,        0, "lb_fff");    pin("pin_lb_fff", 32'h0000005A);

        request(1'b1, 3'b010, 32'h021, 32'hCAFEF00D, 1, "sw_abort");
        request(1'b0, 3'b010, 32'h020, 32'h0,        0, "lw_020");   pin("pin_lw_020", 32'hFEF00D00);
        request(1'b0, 3'b000, 32'h024, 32'h0,        0, "lb_024");   pin("pin_lb_024", 32'h0);
        request(1'b1, 3'b001, 32'h033, 32'h0000BEEF, 2, "sh_rst");
        request(1'b0, 3'b010, 32'h030, 32'h0,        0, "lw_030");   pin("pin_lw_030", 32'hEF000000);
        request(1'b0, 3'b100, 32'h034, 32'h0,        0, "lbu_034");  pin("pin_lbu_034", 32'h0);
        idle(3);
        #2;

        check32("mem_w3",  mem_words[3],  32'h33440000);
        check32("mem_w4",  mem_words[4],  32'hA5AD1122);
        check32("mem_w8",  mem_words[8],  32'hFEF00D00);
        check32("mem_w9",  mem_words[9],  32'h00000000);
        check32("mem_w12", mem_words[12], 32'hEF000000);
        check32("mem_w13", mem_words[13], 32'h00000000);
        check32("mem_w1023", mem_words[1023], 32'h5A000000);
        diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            if (w !== mem_words[i]) diffs++;
        end
        check32("mem_image_diffs", 32'(diffs), 32'd0);
        check32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store unit between the core's execute stage and the 1K-word data memory.
- Turns RISC-V load/store requests into word-addressed memory accesses. Drives the memory's active-low chip select, its write strobe (low = write) and the byte mask.
- Splits misaligned halfword/word accesses into two consecutive memory cycles and stalls the core meanwhile.
- Sign- or zero-extends load data.

Parameters:
- ADDR_W, 10, memory word-address width; memory spans 4*2**ADDR_W bytes.
- DATA_W, 32, data width; fixed at 32 (byte lanes = 4).

Ports:
- clk  input  1  clock; state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- ls_valid  input  1  load/store request present; held stable by core while stall=1.
- ls_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V size/sign code.
- byte_addr  input  32  byte address.
- store_data  input  32  store data, right-justified.
- load_data  output  32  extended load result; valid when done=1 and ls_store=0.
- done  output  1  request completes this cycle.
- stall  output  1  core must hold PC/inputs this cycle.
- fault  output  1  illegal funct3 or out-of-range access; no memory access issued.
- mem_cs  output  1  memory chip select, active low.
- mem_wr  output  1  0 = write, 1 = read.
- mem_mask  output  4  byte-write enables.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  lane-aligned write data.
- mem_rdata  input  32  asynchronous read data from memory.

Behaviour:
- Reset (async, any time): state=IDLE, hold_data=0. While rst=1: mem_cs=1, mem_wr=1, mem_mask=0, done=0, stall=0, fault=0, load_data=0.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code gives fault=1 and done=1 for that cycle, with no access (mem_cs=1).
- Size: 1/2/4 bytes. off = byte_addr[1:0].
- Range check: byte_addr[31:ADDR_W+2] != 0 gives fault.
- A misaligned access in the top word (word address all-ones, off+size>4) also gives fault, with no access. There is no wrap-around.
- Idle with ls_valid=0: mem_cs=1, mem_wr=1, mem_mask=0, done=0, stall=0.
- FSM states: IDLE, SECOND.
- IDLE, legal request, off+size<=4 (aligned/contained), single cycle, combinational:
  - mem_cs=0, mem_addr=byte_addr[ADDR_W+1:2].
  - Store: mem_wr=0, mem_mask = size-bit mask << off, mem_wdata = store_data << 8*off.
  - Load: mem_wr=1, mem_mask=0, load_data = extend(mem_rdata >> 8*off).
  - done=1, stall=0. State stays IDLE.
- IDLE, legal request, off+size>4 (split), first cycle:
  - Access word A at mem_addr as above. Store mask = 4'b1111 << off, clipped to 4 bits.
  - Load: capture hold_data = mem_rdata >> 8*off at posedge.
  - stall=1, done=0. Next state SECOND.
- SECOND, second cycle:
  - mem_addr = A+1. Second-part byte count n = off+size-4; store mask = (1<<n)-1, mem_wdata = store_data >> 8*(4-off).
  - Load: load_data = extend(hold_data | (mem_rdata << 8*(4-off))).
  - done=1, stall=0. Next state IDLE.
- SECOND with ls_valid=0 (core abort): no access is issued, done=0, and the FSM returns to IDLE. A partial first-half store is not rolled back.
- Reset during SECOND: return to IDLE. The second half is never issued.
- Extension: LB/LH sign-extend bit 7/15. LBU/LHU zero-fill. LW passes 32 bits.
- Store writes take effect on the memory's negedge within the issuing cycle. Outputs are therefore stable from posedge through negedge (driven by the FSM and inputs only).
- Latency: aligned = 0 extra cycles; split = 1 stall cycle.

Decomposition:
- Shared package lsu_pkg:
  - enum for funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - state enum {IDLE, SECOND}.
  - functions size_of(funct3) and extend(data, funct3).
- One sub-module, lsu_lane_shift: combinational mask/shift generation from (off, size, part) for both halves. Used once for store data and once for load alignment.

Test Plan:
- Aligned SW at 0x010, data 0xDEADBEEF, then LW at 0x010 -> write cycle mem_addr=4, mask=1111; load_data=0xDEADBEEF, done=1 same cycle, stall=0.
- SB 0xA5 at 0x013, then LB and LBU at 0x013 -> mask=1000, wdata=0xA5000000; LB=0xFFFFFFA5, LBU=0x000000A5.
- Misaligned SW 0x11223344 at 0x00E:
  - Cycle 1: mem_addr=3, mask=1100, wdata[31:16]=0x3344, stall=1.
  - Cycle 2: mem_addr=4, mask=0011, wdata[15:0]=0x1122, done=1.
  - Then LW at 0x00E -> 0x11223344 after 1 stall.
- Misaligned LH at 0x007 with mem bytes 0x007=0x80, 0x008=0x01 -> two cycles, load_data=0x00000180. Repeat with 0x008=0xF0 -> LH=0xFFFFF080, LHU=0x0000F080.
- Faults:
  - funct3=011 load -> fault=1, mem_cs=1.
  - LW at 0x1000 -> fault.
  - LW at 0xFFE -> fault (top-word split). No memory content changes.
- rst asserted during SECOND of a split SW -> outputs return to reset values immediately. Only the first-half bytes are written. Next request starts in IDLE.
